// File: rtl/ntt_bfly_addr_gen_pkg.sv
// rtl/ntt_bfly_addr_gen_pkg.sv - shared types and constants for the NTT butterfly address generator
package ntt_bfly_addr_gen_pkg;

    localparam int LOG_N_DEFAULT = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Butterfly transfers in one full schedule: LOG_N stages of N/2 butterflies.
    function automatic int xfer_count(input int log_n);
        return log_n * (1 << (log_n - 1));
    endfunction

endpackage

// File: rtl/ntt_bfly_addr_gen_stage_counter.sv
// rtl/ntt_bfly_addr_gen_stage_counter.sv - up/down counter with load, enable and terminal-count flag
module ntt_bfly_addr_gen_stage_counter #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    input  logic         down,
    input  logic [W-1:0] term,
    output logic [W-1:0] count,
    output logic         tc
);

    assign tc = (count == term);

    // Reaching terminal count while enabled reloads, so the index counter wraps per stage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en) begin
            if (tc)
                count <= load_val;
            else if (down)
                count <= count - W'(1);
            else
                count <= count + W'(1);
        end
    end

endmodule

// File: rtl/ntt_bfly_addr_gen.sv
// rtl/ntt_bfly_addr_gen.sv - butterfly schedule sequencer emitting address pairs, twiddle index and stage
module ntt_bfly_addr_gen
    import ntt_bfly_addr_gen_pkg::*;
#(
    parameter  int LOG_N = LOG_N_DEFAULT,
    localparam int STG_W = (LOG_N > 2) ? $clog2(LOG_N) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               inverse,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [LOG_N-1:0]   addr_a,
    output logic [LOG_N-1:0]   addr_b,
    output logic [LOG_N-2:0]   tw_idx,
    output logic [STG_W-1:0]   stage,
    output logic               busy,
    output logic               done
);

    localparam int              IW     = LOG_N - 1;
    localparam int              N_HALF = 1 << (LOG_N - 1);
    localparam logic [STG_W-1:0] S_LAST = STG_W'(LOG_N - 1);
    localparam logic [IW-1:0]    I_LAST = IW'(N_HALF - 1);

    state_e           state;
    logic             dir;
    logic [STG_W-1:0] s;
    logic [IW-1:0]    i;
    logic             s_tc;
    logic             i_tc;
    logic             hs;
    logic             start_go;

    assign hs       = out_valid & out_ready;
    assign start_go = (state == ST_IDLE) & start;

    ntt_bfly_addr_gen_stage_counter #(.W(STG_W)) u_stage_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (start_go),
        .load_val (inverse ? S_LAST : '0),
        .en       (hs & i_tc & ~s_tc),
        .down     (dir),
        .term     (dir ? '0 : S_LAST),
        .count    (s),
        .tc       (s_tc)
    );

    ntt_bfly_addr_gen_stage_counter #(.W(IW)) u_index_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (start_go),
        .load_val ('0),
        .en       (hs),
        .down     (1'b0),
        .term     (I_LAST),
        .count    (i),
        .tc       (i_tc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            dir       <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state     <= ST_RUN;
                        dir       <= inverse;
                        out_valid <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (hs && i_tc && s_tc) begin
                        state     <= ST_DONE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state     <= ST_IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

    // j = low s bits of i, k = i >> s; the mask wraps to all ones on the last stage.
    logic [IW-1:0]    j_mask;
    logic [IW-1:0]    j;
    logic [IW-1:0]    k;
    logic [STG_W:0]   s_p1;
    logic [STG_W:0]   tw_sh;
    logic [LOG_N-1:0] pair_a;
    logic [LOG_N-1:0] pair_b;
    logic [IW-1:0]    tw_raw;

    assign j_mask = (IW'(1) << s) - IW'(1);
    assign j      = i & j_mask;
    assign k      = i >> s;
    assign s_p1   = {1'b0, s} + (STG_W + 1)'(1);
    assign tw_sh  = (STG_W + 1)'(LOG_N - 1) - {1'b0, s};
    assign pair_a = ({1'b0, k} << s_p1) | {1'b0, j};
    assign pair_b = pair_a | (LOG_N'(1) << s);
    assign tw_raw = j << tw_sh;

    assign addr_a = out_valid ? pair_a : '0;
    assign addr_b = out_valid ? pair_b : '0;
    assign tw_idx = out_valid ? tw_raw : '0;
    assign stage  = out_valid ? s      : '0;

endmodule

// File: tb/tb_ntt_bfly_addr_gen.sv
// tb/tb_ntt_bfly_addr_gen.sv - scoreboard bench for ntt_bfly_addr_gen at LOG_N=3 and LOG_N=2
module tb_ntt_bfly_addr_gen;

    typedef struct {
        int a;
        int b;
        int tw;
        int st;
    } xfer_t;

    logic       clk;
    logic       rst;
    logic       start;
    logic       inverse;
    logic       out_ready;
    logic       start2;
    logic       ready2;

    logic       ov1, busy1, done1;
    logic [2:0] a1, b1;
    logic [1:0] tw1, st1;

    logic       ov2, busy2, done2;
    logic [1:0] a2, b2;
    logic [0:0] tw2, st2;

    int    checks = 0;
    int    errors = 0;
    xfer_t exp1[$];
    xfer_t exp2[$];
    int    len1 = 0, len2 = 0;
    int    hs1 = 0, hs2 = 0;
    int    cyc1 = 0, last_hs1 = 0;
    int    cyc2 = 0, last_hs2 = 0;
    bit    stalled1 = 0;
    xfer_t held1;
    xfer_t e1;
    xfer_t e2;

    ntt_bfly_addr_gen #(.LOG_N(3)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .inverse   (inverse),
        .out_valid (ov1),
        .out_ready (out_ready),
        .addr_a    (a1),
        .addr_b    (b1),
        .tw_idx    (tw1),
        .stage     (st1),
        .busy      (busy1),
        .done      (done1)
    );

    ntt_bfly_addr_gen #(.LOG_N(2)) u_dut2 (
        .clk       (clk),
        .rst       (rst),
        .start     (start2),
        .inverse   (inverse),
        .out_valid (ov2),
        .out_ready (ready2),
        .addr_a    (a2),
        .addr_b    (b2),
        .tw_idx    (tw2),
        .stage     (st2),
        .busy      (busy2),
        .done      (done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference schedule: stage by stage, group by group, butterfly j within a group of 2m.
    task automatic push_run(input int which, input int log_n, input bit inv);
        int nh = 1 << (log_n - 1);
        int cnt = 0;
        for (int n = 0; n < log_n; n++) begin
            int s = inv ? (log_n - 1 - n) : n;
            int m = 1 << s;
            for (int g = 0; g < nh / m; g++) begin
                for (int j = 0; j < m; j++) begin
                    xfer_t x;
                    x.a  = g * 2 * m + j;
                    x.b  = x.a + m;
                    x.tw = j * (nh / m);
                    x.st = s;
                    if (which == 1) exp1.push_back(x);
                    else            exp2.push_back(x);
                    cnt++;
                end
            end
        end
        if (which == 1) len1 = cnt;
        else            len2 = cnt;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            exp1.delete();
            hs1      = 0;
            stalled1 = 0;
        end else begin
            cyc1++;
            if (ov1) begin
                check("busy_run1", busy1, 1);
                if (stalled1)
                    check("stall_hold1", (a1 == held1.a && b1 == held1.b &&
                                          tw1 == held1.tw && st1 == held1.st) ? 1 : 0, 1);
                if (out_ready) begin
                    check("xfer_expected1", (exp1.size() > 0) ? 1 : 0, 1);
                    if (exp1.size() > 0) begin
                        e1 = exp1.pop_front();
                        check("addr_a1", a1, e1.a);
                        check("addr_b1", b1, e1.b);
                        check("tw_idx1", tw1, e1.tw);
                        check("stage1", st1, e1.st);
                    end
                    hs1++;
                    last_hs1 = cyc1;
                    stalled1 = 0;
                end else begin
                    stalled1 = 1;
                    held1.a  = a1;
                    held1.b  = b1;
                    held1.tw = tw1;
                    held1.st = st1;
                end
            end else begin
                stalled1 = 0;
                check("busy_idle1", busy1, 0);
            end
            if (done1) begin
                check("done_queue_empty1", exp1.size(), 0);
                check("done_xfer_count1", hs1, len1);
                check("done_latency1", cyc1 - last_hs1, 1);
                hs1 = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            exp2.delete();
            hs2 = 0;
        end else begin
            cyc2++;
            if (ov2 && ready2) begin
                check("xfer_expected2", (exp2.size() > 0) ? 1 : 0, 1);
                if (exp2.size() > 0) begin
                    e2 = exp2.pop_front();
                    check("addr_a2", a2, e2.a);
                    check("addr_b2", b2, e2.b);
                    check("tw_idx2", tw2, e2.tw);
                    check("stage2", st2, e2.st);
                end
                hs2++;
                last_hs2 = cyc2;
            end
            if (done2) begin
                check("done_queue_empty2", exp2.size(), 0);
                check("done_xfer_count2", hs2, len2);
                check("done_latency2", cyc2 - last_hs2, 1);
                hs2 = 0;
            end
        end
    end

    task automatic wait_done(input int which, input bit rnd);
        bit got = 0;
        for (int t = 0; t < 400; t++) begin
            if (rnd) begin
                if (which == 1) out_ready = 1'($urandom_range(0, 1));
                else            ready2    = 1'($urandom_range(0, 1));
            end
            if (which == 1) inverse = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            if ((which == 1 && done1) || (which == 2 && done2)) begin
                got = 1;
                break;
            end
        end
        check((which == 1) ? "run_done1" : "run_done2", got, 1);
    endtask

    task automatic run1(input bit inv, input bit rnd);
        push_run(1, 3, inv);
        inverse   = inv;
        out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("start_latency1", ov1, 1);
        wait_done(1, rnd);
        @(posedge clk);
        #1;
    endtask

    task automatic run2(input bit inv, input bit rnd);
        push_run(2, 2, inv);
        inverse = inv;
        ready2  = 1'b1;
        start2  = 1'b1;
        @(posedge clk);
        #1;
        start2 = 1'b0;
        check("start_latency2", ov2, 1);
        wait_done(2, rnd);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst       = 1'b0;
        start     = 1'b0;
        inverse   = 1'b0;
        out_ready = 1'b0;
        start2    = 1'b0;
        ready2    = 1'b0;
        #1;
        check("reset_outs1", int'({ov1, a1, b1, tw1, st1, busy1, done1}), 0);
        check("reset_outs2", int'({ov2, a2, b2, tw2, st2, busy2, done2}), 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        run1(1'b0, 1'b0);
        run1(1'b1, 1'b0);
        run1(1'b0, 1'b1);
        run1(1'b1, 1'b1);
        run1(1'b0, 1'b1);

        // start pulses during RUN and DONE must not restart the schedule
        push_run(1, 3, 1'b0);
        inverse   = 1'b0;
        out_ready = 1'b1;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(1, 1'b0);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("idle_after_done1", ov1, 0);
        repeat (5) @(posedge clk);
        #1;
        check("no_restart1", ov1, 0);

        // start held high re-triggers two cycles after done
        push_run(1, 3, 1'b0);
        inverse   = 1'b0;
        out_ready = 1'b1;
        start     = 1'b1;
        @(posedge clk);
        #1;
        wait_done(1, 1'b0);
        inverse = 1'b0;
        @(negedge clk);
        #1;
        push_run(1, 3, 1'b0);
        for (n = 1; n <= 6; n++) begin
            @(posedge clk);
            #1;
            if (ov1) break;
        end
        check("restart_gap1", n, 2);
        start = 1'b0;
        wait_done(1, 1'b0);
        @(posedge clk);
        #1;

        // asynchronous reset between edges mid-run
        push_run(1, 3, 1'b0);
        inverse   = 1'b0;
        out_ready = 1'b1;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("midrun_reset_outs1", int'({ov1, a1, b1, tw1, st1, busy1, done1}), 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        run1(1'b0, 1'b0);

        run2(1'b0, 1'b0);
        run2(1'b1, 1'b1);
        run2(1'b0, 1'b1);

        for (int r = 0; r < 4; r++)
            run1(1'($urandom_range(0, 1)), 1'b1);

        repeat (3) @(posedge clk);
        #1;
        check("leftover_expected", exp1.size() + exp2.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
